cpu_bus_ctrl: RTL and testbench
===============================

// Module: cpu_bus_ctrl
// PURPOSE
//  Memory-side stage directly downstream of the CPU bus: consumes addr_out/data_out/ren/wen,
//  returns data_in and rdy. Decodes the CPU map: internal 2 KB work RAM (mirrored $0000-$1FFF),
//  PPU registers ($2000-$3FFF, 8 regs mirrored), OAM DMA trigger ($4014) and cartridge PRG ($8000-$FFFF).
//  Stalls the CPU via rdy for slow targets and for the 256-byte OAM DMA transfer.
// PARAMETERS
//  RAM_AW       11        work RAM address width (2**RAM_AW bytes, mirrored over $0000-$1FFF)
//  DMA_ADDR     16'h4014  write address that starts OAM DMA
//  ACK_TIMEOUT  16        cycles to wait for ppu_ack/prg_ack before abandoning an access
// PORTS
//  clk        in   1   system clock; all state on rising edge
//  b_rst      in   1   asynchronous active-low reset
//  addr_out   in   16  CPU address
//  data_out   in   8   CPU write data
//  ren        in   1   CPU read strobe
//  wen        in   1   CPU write strobe
//  data_in    out  8   read data to CPU (registered)
//  rdy        out  1   1 = CPU may advance; 0 = stall
//  ppu_req    out  1   PPU register access request (held until ack)
//  ppu_we     out  1   1 = write, 0 = read; valid with ppu_req
//  ppu_addr   out  3   PPU register index
//  ppu_wdata  out  8   PPU write data
//  ppu_rdata  in   8   PPU read data, valid with ppu_ack
//  ppu_ack    in   1   single-cycle completion pulse
//  prg_req    out  1   PRG ROM read request (held until ack)
//  prg_addr   out  15  PRG byte address (addr[14:0])
//  prg_rdata  in   8   PRG data, valid with prg_ack
//  prg_ack    in   1   single-cycle completion pulse
//  bus_err    out  1   sticky: an access timed out; cleared only by reset
// BEHAVIOUR
//  Reset: data_in=8'h00, rdy=1, ppu_req=0, ppu_we=0, ppu_addr=0, ppu_wdata=0, prg_req=0, prg_addr=0,
//   bus_err=0, FSM=IDLE, DMA counter=0, open-bus latch=8'h00. Reset mid-access/mid-DMA aborts at once.
//  Strobes sampled only in IDLE with rdy=1. ren&wen together: treated as write.
//  RAM: read -> data_in = ram[addr[RAM_AW-1:0]] at next edge, rdy stays 1 (1-cycle latency).
//   Write -> ram updated at the edge, no stall.
//  PPU/PRG: in the sampling cycle rdy drops combinationally to 0; next edge req=1 with addr/we/wdata.
//   req held until ack; on ack edge req=0, data_in<=rdata (reads), rdy=1 next cycle. Ack while req=0 ignored.
//   PRG writes ($8000-$FFFF) ignored, no stall (mapper writes out of scope).
//  Timeout: counter reset on request; after ACK_TIMEOUT cycles without ack: req=0, bus_err=1,
//   read returns open-bus latch, rdy=1.
//  Unmapped ($4000-$4013, $4015-$7FFF): reads return open-bus latch (last value driven on data_in),
//   1-cycle latency, no stall; writes ignored.
//  OAM DMA: write of P to DMA_ADDR -> rdy=0 from next cycle; for i=0..255: read (P<<8)+i through the
//   normal decode (RAM, PPU or PRG, incl. waits), then write byte to PPU reg 4 ($2004). CPU strobes
//   ignored throughout; rdy=1 the cycle after the 256th write completes. Counter 8 bits, ends on wrap 255->0.
//   P in unmapped range: each read yields open-bus latch. DMA does not update data_in.
//  FSM: IDLE, EXT_WAIT (CPU PPU/PRG access), DMA_RD, DMA_RD_WAIT, DMA_WR, DMA_WR_WAIT.
//   IDLE->EXT_WAIT on PPU/PRG access; ->DMA_RD on DMA_ADDR write; EXT_WAIT->IDLE on ack/timeout;
//   DMA_RD->DMA_WR (RAM) or DMA_RD_WAIT (ext); DMA_WR->DMA_WR_WAIT->DMA_RD, or IDLE after i=255.
// STRUCTURE
//  Package cpu_bus_pkg: region enum (REG_RAM, REG_PPU, REG_DMA, REG_UNMAP, REG_PRG), FSM state enum,
//   address constants ($2000, $4014, $8000), decode function addr->region.
//  Sub-module cpu_ram_2k: single-port synchronous RAM (RAM_AW param, registered read, write-first off).
//  Top holds decode, FSM, DMA counter, timeout counter, open-bus latch.
// TESTING
//  Write $5A to $0001, read $0801 -> data_in=$5A one cycle later, rdy never low.
//  Read $2002, ppu_ack 3 cycles after req with rdata=$80 -> ppu_addr=2, rdy low 4 cycles, data_in=$80.
//  Read $C000, no prg_ack -> after 16 cycles prg_req=0, bus_err=1, data_in=previous value, rdy=1.
//  RAM $0200-$02FF = i; write $02 to $4014 -> 256 PPU writes, ppu_addr=4, ppu_wdata=0..255 in order, rdy=0 throughout.
//  Assert b_rst low at DMA byte 100 -> rdy=1, ppu_req=0 immediately; after release FSM IDLE, next RAM read works.
//  Read $4016 after data_in=$3C -> data_in=$3C, no request issued; simultaneous ren&wen to $0010 performs write.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// CPU memory map: region and FSM state types, map constants, address decoder.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_PPU,
        REG_DMA,
        REG_UNMAP,
        REG_PRG
    } region_t;

    typedef enum logic [2:0] {
        IDLE,
        EXT_WAIT,
        DMA_RD,
        DMA_RD_WAIT,
        DMA_WR,
        DMA_WR_WAIT
    } state_t;

    localparam logic [15:0] PPU_BASE = 16'h2000;
    localparam logic [15:0] IO_BASE  = 16'h4000;
    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] PRG_BASE = 16'h8000;
    localparam logic [2:0]  OAM_DATA = 3'd4;

    // The DMA trigger address is checked first so it can be moved anywhere.
    function automatic region_t decode(input logic [15:0] a, input logic [15:0] dma_addr);
        if (a == dma_addr)     return REG_DMA;
        else if (a < PPU_BASE) return REG_RAM;
        else if (a < IO_BASE)  return REG_PPU;
        else if (a >= PRG_BASE) return REG_PRG;
        else                   return REG_UNMAP;
    endfunction

endpackage

// File: rtl/cpu_ram_2k.sv
// Work RAM: single port, registered read returning the old word on a write.
module cpu_ram_2k #(
    parameter int RAM_AW = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**RAM_AW];

    // Write and registered read share the one address port.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU-side bus controller: address decode, PPU/PRG handshakes with timeout,
// open-bus behaviour and 256-byte OAM DMA into PPU register 4.
module cpu_bus_ctrl
    import cpu_bus_pkg::*;
#(
    parameter int          RAM_AW      = 11,
    parameter logic [15:0] DMA_ADDR    = DMA_REG,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        b_rst,
    input  logic [15:0] addr_out,
    input  logic [7:0]  data_out,
    input  logic        ren,
    input  logic        wen,
    output logic [7:0]  data_in,
    output logic        rdy,
    output logic        ppu_req,
    output logic        ppu_we,
    output logic [2:0]  ppu_addr,
    output logic [7:0]  ppu_wdata,
    input  logic [7:0]  ppu_rdata,
    input  logic        ppu_ack,
    output logic        prg_req,
    output logic [14:0] prg_addr,
    input  logic [7:0]  prg_rdata,
    input  logic        prg_ack,
    output logic        bus_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t      state, state_n;
    logic        ppu_req_n, ppu_we_n, prg_req_n, bus_err_n;
    logic [2:0]  ppu_addr_n;
    logic [7:0]  ppu_wdata_n;
    logic [14:0] prg_addr_n;
    logic [TW-1:0] tmo_cnt, tmo_n;
    logic [7:0]  dma_page, dma_page_n, dma_cnt, dma_cnt_n, dma_byte, dma_byte_n;
    logic        dma_ram, dma_ram_n;
    logic [7:0]  data_q, data_q_n;   // open-bus latch: last value on data_in
    logic        ram_sel, ram_sel_n; // data_in comes straight from the RAM this cycle

    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_rdata;

    region_t     cpu_reg, dma_reg;
    logic [15:0] dma_src;
    logic        ack, tmo_hit;
    logic [7:0]  ack_data;

    assign dma_src  = {dma_page, dma_cnt};
    assign cpu_reg  = decode(addr_out, DMA_ADDR);
    assign dma_reg  = decode(dma_src, DMA_ADDR);
    assign ack      = (ppu_req & ppu_ack) | (prg_req & prg_ack);
    assign ack_data = ppu_req ? ppu_rdata : prg_rdata;
    assign tmo_hit  = (tmo_cnt == TW'(ACK_TIMEOUT - 1));
    assign data_in  = ram_sel ? ram_rdata : data_q;

    cpu_ram_2k #(.RAM_AW(RAM_AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_out),
        .rdata (ram_rdata)
    );

    // Next-state, next-output and stall decision.
    always_comb begin
        state_n     = state;
        ppu_req_n   = ppu_req;
        ppu_we_n    = ppu_we;
        ppu_addr_n  = ppu_addr;
        ppu_wdata_n = ppu_wdata;
        prg_req_n   = prg_req;
        prg_addr_n  = prg_addr;
        bus_err_n   = bus_err;
        tmo_n       = tmo_cnt;
        dma_page_n  = dma_page;
        dma_cnt_n   = dma_cnt;
        dma_byte_n  = dma_byte;
        dma_ram_n   = dma_ram;
        data_q_n    = data_in;
        ram_sel_n   = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = addr_out[RAM_AW-1:0];
        rdy         = (state == IDLE);
        case (state)
            IDLE: if (ren | wen) begin
                case (cpu_reg)
                    REG_RAM: begin
                        ram_we    = wen;
                        ram_sel_n = ~wen;
                    end
                    REG_PPU: begin
                        rdy         = 1'b0;
                        ppu_req_n   = 1'b1;
                        ppu_we_n    = wen;
                        ppu_addr_n  = addr_out[2:0];
                        ppu_wdata_n = data_out;
                        tmo_n       = '0;
                        state_n     = EXT_WAIT;
                    end
                    REG_PRG: if (!wen) begin
                        rdy        = 1'b0;
                        prg_req_n  = 1'b1;
                        prg_addr_n = addr_out[14:0];
                        tmo_n      = '0;
                        state_n    = EXT_WAIT;
                    end
                    REG_DMA: if (wen) begin
                        dma_page_n = data_out;
                        dma_cnt_n  = 8'd0;
                        state_n    = DMA_RD;
                    end
                    default: ;
                endcase
            end
            EXT_WAIT: begin
                if (ack) begin
                    if (prg_req || !ppu_we) data_q_n = ack_data;
                    ppu_req_n = 1'b0;
                    prg_req_n = 1'b0;
                    state_n   = IDLE;
                end else if (tmo_hit) begin
                    ppu_req_n = 1'b0;
                    prg_req_n = 1'b0;
                    bus_err_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            DMA_RD: begin
                ram_addr = dma_src[RAM_AW-1:0];
                tmo_n    = '0;
                case (dma_reg)
                    REG_RAM: begin
                        dma_ram_n = 1'b1;
                        state_n   = DMA_WR;
                    end
                    REG_PPU: begin
                        ppu_req_n  = 1'b1;
                        ppu_we_n   = 1'b0;
                        ppu_addr_n = dma_src[2:0];
                        state_n    = DMA_RD_WAIT;
                    end
                    REG_PRG: begin
                        prg_req_n  = 1'b1;
                        prg_addr_n = dma_src[14:0];
                        state_n    = DMA_RD_WAIT;
                    end
                    default: begin
                        dma_byte_n = data_q;
                        dma_ram_n  = 1'b0;
                        state_n    = DMA_WR;
                    end
                endcase
            end
            DMA_RD_WAIT: begin
                if (ack || tmo_hit) begin
                    dma_byte_n = ack ? ack_data : data_q;
                    bus_err_n  = bus_err | ~ack;
                    dma_ram_n  = 1'b0;
                    ppu_req_n  = 1'b0;
                    prg_req_n  = 1'b0;
                    state_n    = DMA_WR;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            DMA_WR: begin
                ppu_req_n   = 1'b1;
                ppu_we_n    = 1'b1;
                ppu_addr_n  = OAM_DATA;
                ppu_wdata_n = dma_ram ? ram_rdata : dma_byte;
                tmo_n       = '0;
                state_n     = DMA_WR_WAIT;
            end
            DMA_WR_WAIT: begin
                if (ack || tmo_hit) begin
                    bus_err_n = bus_err | ~ack;
                    ppu_req_n = 1'b0;
                    dma_cnt_n = dma_cnt + 8'd1;
                    state_n   = (dma_cnt == 8'hFF) ? IDLE : DMA_RD;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any access or DMA immediately.
    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state     <= IDLE;
            ppu_req   <= 1'b0;
            ppu_we    <= 1'b0;
            ppu_addr  <= 3'd0;
            ppu_wdata <= 8'h00;
            prg_req   <= 1'b0;
            prg_addr  <= 15'd0;
            bus_err   <= 1'b0;
            tmo_cnt   <= '0;
            dma_page  <= 8'h00;
            dma_cnt   <= 8'h00;
            dma_byte  <= 8'h00;
            dma_ram   <= 1'b0;
            data_q    <= 8'h00;
            ram_sel   <= 1'b0;
        end else begin
            state     <= state_n;
            ppu_req   <= ppu_req_n;
            ppu_we    <= ppu_we_n;
            ppu_addr  <= ppu_addr_n;
            ppu_wdata <= ppu_wdata_n;
            prg_req   <= prg_req_n;
            prg_addr  <= prg_addr_n;
            bus_err   <= bus_err_n;
            tmo_cnt   <= tmo_n;
            dma_page  <= dma_page_n;
            dma_cnt   <= dma_cnt_n;
            dma_byte  <= dma_byte_n;
            dma_ram   <= dma_ram_n;
            data_q    <= data_q_n;
            ram_sel   <= ram_sel_n;
        end
    end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Bench for cpu_bus_ctrl: CPU read scoreboard, PPU/PRG responder, DMA write scoreboard.
module tb_cpu_bus_ctrl;

    logic        clk = 1'b0;
    logic        b_rst = 1'b0;
    logic [15:0] addr_out = '0;
    logic [7:0]  data_out = '0;
    logic        ren = 1'b0, wen = 1'b0;
    logic [7:0]  data_in;
    logic        rdy;
    logic        ppu_req, ppu_we;
    logic [2:0]  ppu_addr;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata = '0;
    logic        ppu_ack = 1'b0;
    logic        prg_req;
    logic [14:0] prg_addr;
    logic [7:0]  prg_rdata = '0;
    logic        prg_ack = 1'b0;
    logic        bus_err;

    int n_cmp = 0, n_bad = 0;
    int low_cnt = 0, nreq = 0, nwr = 0;
    int ppu_cyc = 0, prg_cyc = 0;
    int ppu_dly = 1, prg_dly = 0;   // ack in the Nth cycle of a request; 0 = never
    logic [7:0]  ppu_rd_val = '0;
    logic [2:0]  last_ppu_addr = '0;
    logic        last_ppu_we = 1'b0;
    logic [14:0] last_prg_addr = '0;
    logic [7:0]  rd_q[$];   // expected CPU read data
    logic [7:0]  wr_q[$];   // expected DMA bytes written to the PPU

    cpu_bus_ctrl dut (
        .clk(clk), .b_rst(b_rst), .addr_out(addr_out), .data_out(data_out),
        .ren(ren), .wen(wen), .data_in(data_in), .rdy(rdy),
        .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata),
        .ppu_rdata(ppu_rdata), .ppu_ack(ppu_ack),
        .prg_req(prg_req), .prg_addr(prg_addr), .prg_rdata(prg_rdata), .prg_ack(prg_ack),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stall cycles as seen by the CPU.
    always @(negedge clk) if (b_rst && !rdy) low_cnt++;

    // PPU/PRG responder; DMA writes are scored against wr_q as they complete.
    always @(posedge clk) begin
        #1;
        if (ppu_req) begin
            ppu_cyc++;
            if (ppu_cyc == 1) begin
                nreq++;
                last_ppu_addr = ppu_addr;
                last_ppu_we   = ppu_we;
            end
            if (ppu_cyc == ppu_dly) begin
                ppu_ack   = 1'b1;
                ppu_rdata = ppu_rd_val;
                if (ppu_we) begin
                    nwr++;
                    chk("dma_addr", 32'(ppu_addr), 32'd4);
                    if (wr_q.size() == 0) chk("dma_sb_empty", 32'd1, 32'd0);
                    else chk("dma_data", 32'(ppu_wdata), 32'(wr_q.pop_front()));
                end
            end else ppu_ack = 1'b0;
        end else begin
            ppu_cyc = 0;
            ppu_ack = 1'b0;
        end
        if (prg_req) begin
            prg_cyc++;
            if (prg_cyc == 1) begin
                nreq++;
                last_prg_addr = prg_addr;
            end
            prg_ack = (prg_cyc == prg_dly);
        end else begin
            prg_cyc = 0;
            prg_ack = 1'b0;
        end
    end

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        addr_out = a; data_out = d; wen = 1'b1;
        @(posedge clk); #2;
        wen = 1'b0;
    endtask

    // Issue a read, wait for rdy, then score data_in against the queued value.
    task automatic cpu_rd(input logic [15:0] a, input logic [7:0] exp);
        rd_q.push_back(exp);
        @(posedge clk); #2;
        addr_out = a; ren = 1'b1;
        @(posedge clk); #2;
        ren = 1'b0;
        for (int i = 0; i < 64 && !rdy; i++) begin
            @(posedge clk); #2;
        end
        if (!rdy) chk("rd_rdy_timeout", 32'(rdy), 32'd1);
        chk("rd_data", 32'(data_in), 32'(rd_q.pop_front()));
    endtask

    initial begin
        int lo0, rq0, wr0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_data_in", 32'(data_in), 32'h00);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_ppu_req", 32'(ppu_req), 32'd0);
        chk("rst_prg_req", 32'(prg_req), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        b_rst = 1'b1;

        // RAM mirror: write $0001, read $0801, never stalled
        lo0 = low_cnt;
        cpu_wr(16'h0001, 8'h5A);
        cpu_rd(16'h0801, 8'h5A);
        chk("ram_stall", 32'(low_cnt - lo0), 32'd0);

        // PPU read of $2002, ack in the 3rd request cycle
        ppu_dly = 3; ppu_rd_val = 8'h80;
        lo0 = low_cnt;
        cpu_rd(16'h2002, 8'h80);
        chk("ppu_stall", 32'(low_cnt - lo0), 32'd4);
        chk("ppu_addr", 32'(last_ppu_addr), 32'd2);
        chk("ppu_we", 32'(last_ppu_we), 32'd0);
        chk("ppu_no_err", 32'(bus_err), 32'd0);

        // PRG read of $C000 with no ack: timeout, open-bus data
        prg_dly = 0;
        lo0 = low_cnt;
        cpu_rd(16'hC000, 8'h80);
        chk("tmo_stall", 32'(low_cnt - lo0), 32'd17);
        chk("tmo_prg_addr", 32'(last_prg_addr), 32'h4000);
        chk("tmo_prg_req", 32'(prg_req), 32'd0);
        chk("tmo_bus_err", 32'(bus_err), 32'd1);

        // PRG read that is acked returns ROM data
        prg_dly = 2; prg_rdata = 8'hC3;
        cpu_rd(16'hFFFC, 8'hC3);
        chk("prg_addr", 32'(last_prg_addr), 32'h7FFC);

        // Unmapped read keeps the last data_in and issues no request
        cpu_wr(16'h0005, 8'h3C);
        cpu_rd(16'h0005, 8'h3C);
        rq0 = nreq; lo0 = low_cnt;
        cpu_rd(16'h4016, 8'h3C);
        chk("unmap_nreq", 32'(nreq - rq0), 32'd0);
        chk("unmap_stall", 32'(low_cnt - lo0), 32'd0);

        // PRG write ignored without stalling
        lo0 = low_cnt;
        cpu_wr(16'h8000, 8'hEE);
        chk("prgw_nreq", 32'(nreq - rq0), 32'd0);
        chk("prgw_stall", 32'(low_cnt - lo0), 32'd0);

        // ren & wen together act as a write
        @(posedge clk); #2;
        addr_out = 16'h0010; data_out = 8'h77; ren = 1'b1; wen = 1'b1;
        @(posedge clk); #2;
        ren = 1'b0; wen = 1'b0;
        cpu_rd(16'h0010, 8'h77);

        // OAM DMA from page $02 holding i at $02xx
        for (int i = 0; i < 256; i++) cpu_wr(16'h0200 + 16'(i), 8'(i));
        ppu_dly = 1;
        for (int i = 0; i < 256; i++) wr_q.push_back(8'(i));
        wr0 = nwr;
        cpu_wr(16'h4014, 8'h02);
        for (int i = 0; i < 5000 && !rdy; i++) begin
            @(posedge clk); #2;
            if (rdy) chk("dma_done_writes", 32'(nwr - wr0), 32'd256);
        end
        chk("dma_rdy_back", 32'(rdy), 32'd1);
        chk("dma_sb_drained", 32'(wr_q.size()), 32'd0);
        cpu_rd(16'h0801, 8'h5A);

        // Reset in the middle of a DMA at byte 100
        for (int i = 0; i < 256; i++) wr_q.push_back(8'(i));
        wr0 = nwr;
        cpu_wr(16'h4014, 8'h02);
        for (int i = 0; i < 2000 && (nwr - wr0) < 100; i++) begin
            @(posedge clk); #2;
        end
        chk("mid_dma_count", 32'(nwr - wr0), 32'd100);
        b_rst = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(rdy), 32'd1);
        chk("mid_rst_ppu_req", 32'(ppu_req), 32'd0);
        chk("mid_rst_sb_left", 32'(wr_q.size()), 32'd156);
        repeat (2) @(posedge clk);
        #2;
        b_rst = 1'b1;
        wr0 = nwr;
        cpu_rd(16'h0801, 8'h5A);
        chk("post_rst_rdy", 32'(rdy), 32'd1);
        chk("post_rst_no_dma", 32'(nwr - wr0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
